cpu_mem_port_ctrl: RTL and testbench
====================================

// Module: cpu_mem_port_ctrl
// PURPOSE
//  Parametrised multi-port memory-access controller between the CPU pipeline and its bus master ports.
//  Generalises the fixed IM/DM req/wait glue to NUM_PORTS channels.
//  Each port holds a latched request until its slave completes, then captures read data.
//  Pipeline stall is raised until every port of the current access group has completed.
//  Adds per-port timeout with a sticky error, which the fixed two-port glue lacks.
// PARAMETERS
//  NUM_PORTS   2      number of independent master ports (port 0 = fetch by convention)
//  ADDR_BITS   32     address width per port
//  DATA_BITS   32     data width per port
//  WEB_BITS    4      byte write-enable width per port
//  TIMEOUT_CYC 0      BUSY cycles before forced completion; 0 disables timeout
//  ERR_DATA    32'h0  read data returned on a timed-out access
// PORTS
//  clk           in   1                    clock, rising edge
//  rstn          in   1                    reset, asynchronous, active-low
//  pipe_req_i    in   NUM_PORTS            pipeline requests access on port p
//  pipe_wr_i     in   NUM_PORTS            1 = write, 0 = read
//  pipe_addr_i   in   NUM_PORTS*ADDR_BITS  access address, port p in slice p
//  pipe_wdata_i  in   NUM_PORTS*DATA_BITS  write data
//  pipe_web_i    in   NUM_PORTS*WEB_BITS   byte write enables
//  pipe_rdata_o  out  NUM_PORTS*DATA_BITS  captured read data
//  stall_o       out  1                    freeze pipeline registers
//  bus_req_o     out  NUM_PORTS            request to slave
//  bus_read_o    out  NUM_PORTS            read strobe
//  bus_write_o   out  NUM_PORTS            write strobe
//  bus_addr_o    out  NUM_PORTS*ADDR_BITS  latched address
//  bus_wdata_o   out  NUM_PORTS*DATA_BITS  latched write data
//  bus_web_o     out  NUM_PORTS*WEB_BITS   latched byte enables
//  bus_wait_i    in   NUM_PORTS            1 = slave not yet done
//  bus_rdata_i   in   NUM_PORTS*DATA_BITS  slave read data, valid when BUSY & ~wait
//  err_clr_i     in   1                    clears err_o
//  err_o         out  NUM_PORTS            sticky timeout flag per port
// BEHAVIOUR
//  Reset (rstn=0, async):
//   - all ports IDLE; timeout counters, rdata regs, latches and err_o cleared to 0
//   - all outputs 0; an in-flight access is abandoned (bus_req_o drops immediately)
//  Per-port FSM states: IDLE, BUSY, DONE.
//  Group state:
//   - group idle = no port in BUSY or DONE
//   - group start: group idle & |pipe_req_i; every requesting port latches wr/addr/wdata/web and goes BUSY
//   - non-requesting ports stay IDLE for the whole group
//   - pipe_* inputs are ignored between group start and release
//  BUSY:
//   - bus_req_o=1; bus_read_o=~wr; bus_write_o=wr; bus_* driven from latches
//   - completes in the first cycle with bus_wait_i=0, which may be the first BUSY cycle
//   - on completion of a read: rdata reg <= bus_rdata_i (a write leaves rdata unchanged); next state DONE
//  Timeout:
//   - if TIMEOUT_CYC>0 and counter==TIMEOUT_CYC-1 while bus_wait_i=1: force completion, rdata <= ERR_DATA, err_o[p] <= 1
//   - counter resets on entry to BUSY
//   - a slave completion in the same cycle wins: real data is captured and err_o is not set
//  Release:
//   - group active & no port BUSY (at least one DONE) -> all DONE ports go IDLE next cycle
//   - pipe_rdata_o is valid in this release cycle
//  stall_o is combinational:
//   - (group idle & |pipe_req_i) | (any port BUSY)
//   - low in the release cycle and when there are no requests
//  Latency: zero-wait slave = 2 stall cycles (start, BUSY), then the release cycle.
//   - a slave waiting N cycles adds N stall cycles
//  Multi-port completion:
//   - ports may complete in any order or in the same cycle
//   - a finished port holds DONE with bus_req_o=0 until the group releases
//  pipe_rdata_o holds its value until the next completion on that port.
//  err_o:
//   - sticky; cleared by err_clr_i the next cycle
//   - a new set in the same cycle as err_clr_i wins
//  Widths: slices are packed LSB-first; no arithmetic beyond the timeout counter of width $clog2(TIMEOUT_CYC+1).
// TESTING
//  1. Zero-wait read, port0 addr 0x100 (bus_rdata 0xDEADBEEF), port1 idle:
//     -> stall high 2 cycles, then release with pipe_rdata[0]=0xDEADBEEF; bus_req[1] never asserted.
//  2. Both ports request; port0 waits 1 cycle, port1 waits 4:
//     -> port0 DONE with req low from cycle 3; stall high 6 cycles; both rdata valid in release.
//  3. Write on port1: addr 0x200, wdata 0x12345678, web 4'b0011
//     -> bus_write=1, bus_read=0 with those latched values held while wait=1; pipe_rdata[1] unchanged.
//  4. TIMEOUT_CYC=8, slave holds wait=1
//     -> forced completion after 8 BUSY cycles, rdata=ERR_DATA, err_o[p]=1 until err_clr_i.
//  5. Completion in the same cycle as the timeout edge -> real data captured, err_o stays 0.
//  6. rstn low mid-BUSY -> bus_req_o, stall_o, err_o all 0 immediately; after release, the next request behaves as test 1.

Source files
------------

// File: rtl/cpu_mem_port_ctrl.sv
// Multi-port memory-access controller: latches grouped pipeline requests onto bus master ports,
// stalls the pipeline until every port of the group completes, with optional per-port timeout.
module cpu_mem_port_ctrl #(
    parameter int unsigned         NUM_PORTS   = 2,
    parameter int unsigned         ADDR_BITS   = 32,
    parameter int unsigned         DATA_BITS   = 32,
    parameter int unsigned         WEB_BITS    = 4,
    parameter int unsigned         TIMEOUT_CYC = 0,
    parameter logic [DATA_BITS-1:0] ERR_DATA   = '0
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_PORTS-1:0]           pipe_req_i,
    input  logic [NUM_PORTS-1:0]           pipe_wr_i,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] pipe_addr_i,
    input  logic [NUM_PORTS*DATA_BITS-1:0] pipe_wdata_i,
    input  logic [NUM_PORTS*WEB_BITS-1:0]  pipe_web_i,
    output logic [NUM_PORTS*DATA_BITS-1:0] pipe_rdata_o,
    output logic                           stall_o,
    output logic [NUM_PORTS-1:0]           bus_req_o,
    output logic [NUM_PORTS-1:0]           bus_read_o,
    output logic [NUM_PORTS-1:0]           bus_write_o,
    output logic [NUM_PORTS*ADDR_BITS-1:0] bus_addr_o,
    output logic [NUM_PORTS*DATA_BITS-1:0] bus_wdata_o,
    output logic [NUM_PORTS*WEB_BITS-1:0]  bus_web_o,
    input  logic [NUM_PORTS-1:0]           bus_wait_i,
    input  logic [NUM_PORTS*DATA_BITS-1:0] bus_rdata_i,
    input  logic                           err_clr_i,
    output logic [NUM_PORTS-1:0]           err_o
);

    // Counter keeps a 1-bit width when timeout is disabled so the declaration stays legal.
    localparam int unsigned CNT_W = (TIMEOUT_CYC != 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic                 wr;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] wdata;
        logic [WEB_BITS-1:0]  web;
    } lat_t;

    state_e                         state_q [NUM_PORTS];
    state_e                         state_d [NUM_PORTS];
    lat_t                           lat_q   [NUM_PORTS];
    lat_t                           lat_d   [NUM_PORTS];
    logic [CNT_W-1:0]               cnt_q   [NUM_PORTS];
    logic [CNT_W-1:0]               cnt_d   [NUM_PORTS];
    logic [NUM_PORTS*DATA_BITS-1:0] rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]           err_q, err_d;

    logic [NUM_PORTS-1:0] busy_c;
    logic [NUM_PORTS-1:0] done_c;
    logic                 group_idle_c;
    logic                 release_c;

    // Group status decoded from the per-port states.
    always_comb begin
        busy_c = '0;
        done_c = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            busy_c[p] = (state_q[p] == ST_BUSY);
            done_c[p] = (state_q[p] == ST_DONE);
        end
        group_idle_c = ~|(busy_c | done_c);
        release_c    = ~group_idle_c & ~|busy_c;
    end

    assign stall_o = (group_idle_c & |pipe_req_i) | |busy_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= ST_IDLE;
                lat_q[p]   <= '0;
                cnt_q[p]   <= '0;
            end
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Per-port next state: start, completion or timeout, and group release.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_clr_i ? '0 : err_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            case (state_q[p])
                ST_IDLE: begin
                    if (group_idle_c && pipe_req_i[p]) begin
                        state_d[p]       = ST_BUSY;
                        lat_d[p].wr      = pipe_wr_i[p];
                        lat_d[p].addr    = pipe_addr_i[p*ADDR_BITS +: ADDR_BITS];
                        lat_d[p].wdata   = pipe_wdata_i[p*DATA_BITS +: DATA_BITS];
                        lat_d[p].web     = pipe_web_i[p*WEB_BITS +: WEB_BITS];
                        cnt_d[p]         = '0;
                    end
                end
                ST_BUSY: begin
                    if (!bus_wait_i[p]) begin
                        state_d[p] = ST_DONE;
                        if (!lat_q[p].wr) begin
                            rdata_d[p*DATA_BITS +: DATA_BITS] = bus_rdata_i[p*DATA_BITS +: DATA_BITS];
                        end
                    end else if ((TIMEOUT_CYC != 0) && (cnt_q[p] == CNT_W'(TIMEOUT_CYC - 1))) begin
                        state_d[p]                        = ST_DONE;
                        rdata_d[p*DATA_BITS +: DATA_BITS] = ERR_DATA;
                        err_d[p]                          = 1'b1;
                    end else if (TIMEOUT_CYC != 0) begin
                        cnt_d[p] = cnt_q[p] + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (release_c) begin
                        state_d[p] = ST_IDLE;
                    end
                end
                default: state_d[p] = ST_IDLE;
            endcase
        end
    end

    // Bus side is driven straight from the latched request while the port is BUSY.
    always_comb begin
        bus_req_o   = '0;
        bus_read_o  = '0;
        bus_write_o = '0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        bus_web_o   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus_req_o[p]                          = busy_c[p];
            bus_read_o[p]                         = busy_c[p] & ~lat_q[p].wr;
            bus_write_o[p]                        = busy_c[p] & lat_q[p].wr;
            bus_addr_o[p*ADDR_BITS +: ADDR_BITS]  = lat_q[p].addr;
            bus_wdata_o[p*DATA_BITS +: DATA_BITS] = lat_q[p].wdata;
            bus_web_o[p*WEB_BITS +: WEB_BITS]     = lat_q[p].web;
        end
    end

    assign pipe_rdata_o = rdata_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_cpu_mem_port_ctrl.sv
// Self-checking bench for cpu_mem_port_ctrl: transaction-level model of access groups,
// per-cycle comparison on the falling edge, directed scenarios followed by random groups.
module tb_cpu_mem_port_ctrl;

    localparam int unsigned NP   = 2;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned WW   = 4;
    localparam int unsigned TO   = 8;
    localparam logic [DW-1:0] ERRD = 32'hE77D_0BAD;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [NP-1:0]    pipe_req_i = '0;
    logic [NP-1:0]    pipe_wr_i = '0;
    logic [NP*AW-1:0] pipe_addr_i = '0;
    logic [NP*DW-1:0] pipe_wdata_i = '0;
    logic [NP*WW-1:0] pipe_web_i = '0;
    logic [NP*DW-1:0] pipe_rdata_o;
    logic             stall_o;
    logic [NP-1:0]    bus_req_o, bus_read_o, bus_write_o;
    logic [NP*AW-1:0] bus_addr_o;
    logic [NP*DW-1:0] bus_wdata_o;
    logic [NP*WW-1:0] bus_web_o;
    logic [NP-1:0]    bus_wait_i = '0;
    logic [NP*DW-1:0] bus_rdata_i = '0;
    logic             err_clr_i = 1'b0;
    logic [NP-1:0]    err_o;

    cpu_mem_port_ctrl #(
        .NUM_PORTS(NP), .ADDR_BITS(AW), .DATA_BITS(DW), .WEB_BITS(WW),
        .TIMEOUT_CYC(TO), .ERR_DATA(ERRD)
    ) dut (
        .clk(clk), .rstn(rstn),
        .pipe_req_i(pipe_req_i), .pipe_wr_i(pipe_wr_i), .pipe_addr_i(pipe_addr_i),
        .pipe_wdata_i(pipe_wdata_i), .pipe_web_i(pipe_web_i), .pipe_rdata_o(pipe_rdata_o),
        .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_read_o(bus_read_o),
        .bus_write_o(bus_write_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_web_o(bus_web_o), .bus_wait_i(bus_wait_i), .bus_rdata_i(bus_rdata_i),
        .err_clr_i(err_clr_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NP-1:0]         req;
        logic [NP-1:0]         wr;
        logic [NP-1:0][AW-1:0] addr;
        logic [NP-1:0][DW-1:0] wdata;
        logic [NP-1:0][WW-1:0] web;
        logic [NP-1:0][7:0]    n;     // wait cycles the slave inserts before completing
        logic [NP-1:0][DW-1:0] rd;
    } plan_t;

    int checks = 0;
    int failures = 0;
    int obs_stall = 0;
    int clr_mode = 0;   // 0: never clear, 1: random clear pulses

    logic             chk_en = 1'b0;
    logic             exp_stall = 1'b0;
    logic [NP-1:0]    exp_req = '0, exp_rd = '0, exp_wr = '0, exp_err = '0;
    logic [NP*DW-1:0] exp_rdata = '0;
    logic [AW-1:0]    exp_addr  [NP];
    logic [DW-1:0]    exp_wdata [NP];
    logic [WW-1:0]    exp_web   [NP];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Single compare point against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            if (stall_o) obs_stall++;
            chk("stall", 64'(stall_o), 64'(exp_stall));
            chk("bus_req", 64'(bus_req_o), 64'(exp_req));
            chk("bus_read", 64'(bus_read_o), 64'(exp_rd));
            chk("bus_write", 64'(bus_write_o), 64'(exp_wr));
            chk("err", 64'(err_o), 64'(exp_err));
            chk("pipe_rdata", 64'(pipe_rdata_o), 64'(exp_rdata));
            for (int p = 0; p < NP; p++) begin
                if (exp_req[p]) begin
                    chk("bus_addr", 64'(bus_addr_o[p*AW +: AW]), 64'(exp_addr[p]));
                    chk("bus_wdata", 64'(bus_wdata_o[p*DW +: DW]), 64'(exp_wdata[p]));
                    chk("bus_web", 64'(bus_web_o[p*WW +: WW]), 64'(exp_web[p]));
                end
            end
        end
    end

    function automatic logic pick_clr(input bit force_clr);
        if (force_clr) return 1'b1;
        if (clr_mode == 1) return ($urandom_range(0, 5) == 0);
        return 1'b0;
    endfunction

    task automatic idle_cycles(input int n, input bit force_clr);
        for (int c = 0; c < n; c++) begin
            pipe_req_i   = '0;
            pipe_wr_i    = NP'($urandom);
            pipe_addr_i  = {$urandom, $urandom};
            pipe_wdata_i = {$urandom, $urandom};
            pipe_web_i   = (NP*WW)'($urandom);
            bus_wait_i   = NP'($urandom);
            bus_rdata_i  = {$urandom, $urandom};
            err_clr_i    = pick_clr(force_clr);
            exp_stall = 1'b0;
            exp_req = '0; exp_rd = '0; exp_wr = '0;
            chk_en = 1'b1;
            @(posedge clk); #1;
            if (err_clr_i) exp_err = '0;
        end
    endtask

    // Runs one access group; the model derives each port's BUSY window from its wait count.
    task automatic run_group(input plan_t pl);
        int bc [NP];
        bit tout [NP];
        int tmax;
        logic [NP-1:0]    nerr;
        logic [NP*DW-1:0] nrd;
        logic             busy;
        tmax = 0;
        for (int p = 0; p < NP; p++) begin
            tout[p] = pl.req[p] && (int'(pl.n[p]) >= int'(TO));
            bc[p]   = !pl.req[p] ? 0 : (tout[p] ? int'(TO) : int'(pl.n[p]) + 1);
            if (bc[p] > tmax) tmax = bc[p];
        end
        for (int t = 0; t <= tmax + 1; t++) begin
            if (t == 0) begin
                pipe_req_i = pl.req;
                pipe_wr_i  = pl.wr;
                for (int p = 0; p < NP; p++) begin
                    pipe_addr_i[p*AW +: AW]  = pl.addr[p];
                    pipe_wdata_i[p*DW +: DW] = pl.wdata[p];
                    pipe_web_i[p*WW +: WW]   = pl.web[p];
                end
            end else begin
                pipe_req_i   = NP'($urandom);
                pipe_wr_i    = NP'($urandom);
                pipe_addr_i  = {$urandom, $urandom};
                pipe_wdata_i = {$urandom, $urandom};
                pipe_web_i   = (NP*WW)'($urandom);
            end
            err_clr_i = pick_clr(1'b0);
            nerr      = err_clr_i ? '0 : exp_err;
            nrd       = exp_rdata;
            exp_stall = (t <= tmax);
            for (int p = 0; p < NP; p++) begin
                busy         = pl.req[p] && (t >= 1) && (t <= bc[p]);
                exp_req[p]   = busy;
                exp_rd[p]    = busy && !pl.wr[p];
                exp_wr[p]    = busy && pl.wr[p];
                exp_addr[p]  = pl.addr[p];
                exp_wdata[p] = pl.wdata[p];
                exp_web[p]   = pl.web[p];
                bus_wait_i[p]            = busy ? (t - 1 < int'(pl.n[p])) : 1'($urandom);
                bus_rdata_i[p*DW +: DW]  = busy ? pl.rd[p] : $urandom;
                if (busy && t == bc[p]) begin
                    if (tout[p]) begin
                        nrd[p*DW +: DW] = ERRD;
                        nerr[p]         = 1'b1;
                    end else if (!pl.wr[p]) begin
                        nrd[p*DW +: DW] = pl.rd[p];
                    end
                end
            end
            chk_en = 1'b1;
            @(posedge clk); #1;
            exp_rdata = nrd;
            exp_err   = nerr;
        end
    endtask

    function automatic plan_t rd_plan(input int p, input logic [AW-1:0] a,
                                      input logic [DW-1:0] d, input int n);
        plan_t pl;
        pl = '0;
        pl.req[p]  = 1'b1;
        pl.addr[p] = a;
        pl.rd[p]   = d;
        pl.n[p]    = 8'(n);
        return pl;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        plan_t pl;
        for (int p = 0; p < NP; p++) begin
            exp_addr[p] = '0; exp_wdata[p] = '0; exp_web[p] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", 64'(stall_o), 64'd0);
        chk("reset_busreq", 64'(bus_req_o), 64'd0);
        chk("reset_err", 64'(err_o), 64'd0);
        chk("reset_rdata", 64'(pipe_rdata_o), 64'd0);
        chk("reset_addr", 64'(bus_addr_o), 64'd0);
        rstn = 1'b1;
        idle_cycles(2, 1'b0);

        // Zero-wait read on port 0.
        obs_stall = 0;
        run_group(rd_plan(0, 32'h100, 32'hDEAD_BEEF, 0));
        chk("t1_stall_cycles", 64'(obs_stall), 64'd2);
        chk("t1_rdata0", 64'(pipe_rdata_o[31:0]), 64'hDEAD_BEEF);

        // Both ports; port 0 waits 1, port 1 waits 4.
        pl = rd_plan(0, 32'h140, 32'h1111_2222, 1);
        pl.req[1] = 1'b1; pl.addr[1] = 32'h180; pl.rd[1] = 32'hCAFE_F00D; pl.n[1] = 8'd4;
        obs_stall = 0;
        run_group(pl);
        chk("t2_stall_cycles", 64'(obs_stall), 64'd6);
        chk("t2_rdata", 64'(pipe_rdata_o), 64'hCAFE_F00D_1111_2222);

        // Write on port 1 leaves its read data untouched.
        pl = '0;
        pl.req = 2'b10; pl.wr = 2'b10; pl.addr[1] = 32'h200; pl.wdata[1] = 32'h1234_5678;
        pl.web[1] = 4'b0011; pl.n[1] = 8'd3; pl.rd[1] = 32'h0BAD_0BAD;
        run_group(pl);
        chk("t3_rdata1_kept", 64'(pipe_rdata_o[63:32]), 64'hCAFE_F00D);

        // Timeout on port 0.
        obs_stall = 0;
        run_group(rd_plan(0, 32'h300, 32'h7777_7777, 12));
        chk("t4_stall_cycles", 64'(obs_stall), 64'd9);
        chk("t4_rdata0", 64'(pipe_rdata_o[31:0]), 64'(ERRD));
        idle_cycles(2, 1'b0);
        chk("t4_err_sticky", 64'(err_o), 64'd1);

        // Asynchronous reset while port 0 is BUSY.
        chk_en = 1'b0;
        pipe_req_i = 2'b01; pipe_wr_i = '0; bus_wait_i = 2'b11; err_clr_i = 1'b0;
        @(posedge clk); #1;
        pipe_req_i = '0;
        @(posedge clk); #1;
        chk("t6_busy_before", 64'(bus_req_o), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_busreq", 64'(bus_req_o), 64'd0);
        chk("t6_stall", 64'(stall_o), 64'd0);
        chk("t6_err", 64'(err_o), 64'd0);
        exp_rdata = '0; exp_err = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        obs_stall = 0;
        run_group(rd_plan(0, 32'h100, 32'hDEAD_BEEF, 0));
        chk("t6_stall_cycles", 64'(obs_stall), 64'd2);
        chk("t6_rdata0", 64'(pipe_rdata_o[31:0]), 64'hDEAD_BEEF);

        // Completion on the timeout edge wins over the timeout.
        run_group(rd_plan(1, 32'h400, 32'h55AA_1234, 7));
        chk("t5_err", 64'(err_o), 64'd0);
        chk("t5_rdata1", 64'(pipe_rdata_o[63:32]), 64'h55AA_1234);

        // Sticky error then explicit clear.
        run_group(rd_plan(1, 32'h500, 32'h0, 9));
        chk("t4b_err_set", 64'(err_o), 64'd2);
        idle_cycles(1, 1'b1);
        chk("t4b_err_clr", 64'(err_o), 64'd0);

        // Random groups with random clear pulses.
        clr_mode = 1;
        for (int g = 0; g < 150; g++) begin
            pl = '0;
            pl.req = NP'($urandom_range(1, 3));
            pl.wr  = NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                pl.addr[p]  = $urandom;
                pl.wdata[p] = $urandom;
                pl.web[p]   = WW'($urandom);
                pl.rd[p]    = $urandom;
                pl.n[p]     = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(6, 10))
                                                          : 8'($urandom_range(0, 3));
            end
            run_group(pl);
            idle_cycles($urandom_range(0, 2), 1'b0);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
